// File: rtl/shift_operand_encoder.sv
// Iterative ARM immediate shifter-operand encoder: one rotation tried per clock.
// Optional early exit on first match via SHIFT_OPERAND_ENCODER_EARLY_EXIT_EN.
module shift_operand_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        found,
  output logic [11:0] shift_operand
);

  localparam int unsigned REGISTER_LEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t                  state, state_nx;
  logic [3:0]              r;
  logic [REGISTER_LEN-1:0] val_q;
  logic [3:0]              rot_q;
  logic [7:0]              imm_q;
  logic                    hit;

  logic [4:0]                amt;
  logic [2*REGISTER_LEN-1:0] dbl;
  logic [REGISTER_LEN-1:0]   cand;
  logic                      match;
  logic                      last;

  // Upper half of {v,v} << n is v rotated left by n, including n = 0.
  always_comb begin
    amt   = {r, 1'b0};
    dbl   = {val_q, val_q} << amt;
    cand  = dbl[2*REGISTER_LEN-1:REGISTER_LEN];
    match = (cand[REGISTER_LEN-1:8] == '0);
`ifdef SHIFT_OPERAND_ENCODER_EARLY_EXIT_EN
    last  = (r == 4'd15) || match;
`else
    last  = (r == 4'd15);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SEARCH;
      SEARCH:  if (last)     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      val_q <= '0;
      rot_q <= '0;
      imm_q <= '0;
      hit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            val_q <= value;
            r     <= '0;
            hit   <= 1'b0;
          end
        end
        SEARCH: begin
          // First match wins so the lowest rotation is reported.
          if (match && !hit) begin
            rot_q <= r;
            imm_q <= cand[7:0];
            hit   <= 1'b1;
          end
          if (!last) r <= r + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready      = (state == IDLE);
    out_valid     = (state == DONE);
    found         = out_valid && hit;
    shift_operand = found ? {rot_q, imm_q} : '0;
  end

endmodule

// File: tb/tb_shift_operand_encoder.sv
// Self-checking bench for shift_operand_encoder: vector table, corner sequences,
// and random values checked against a brute-force model of the immediate format.
module tb_shift_operand_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        out_valid;
  logic        out_ready;
  logic        found;
  logic [11:0] shift_operand;

  int checks;
  int errors;

  shift_operand_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .value        (value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .found        (found),
    .shift_operand(shift_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic        exp_found;
    logic [11:0] exp_so;
  } vec_t;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Lowest rotate, then the imm8 that decodes back to v; latency from the timing rules.
  task automatic model(input logic [31:0] v, output logic f, output logic [11:0] so,
                       output int lat);
    f   = 1'b0;
    so  = '0;
    lat = 16;
    for (int unsigned rot = 0; rot < 16 && !f; rot++) begin
      for (int unsigned imm = 0; imm < 256 && !f; imm++) begin
        if (ror32(imm, 2 * rot) == v) begin
          f  = 1'b1;
          so = {rot[3:0], imm[7:0]};
`ifdef SHIFT_OPERAND_ENCODER_EARLY_EXIT_EN
          lat = int'(rot) + 1;
`endif
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for out_valid.
  task automatic request(input logic [31:0] v, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    value    = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    value    = $urandom;
    lat      = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_req(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_req(input logic [31:0] v, input string nm);
    logic        ef;
    logic [11:0] eso;
    int          elat;
    int          lat;
    model(v, ef, eso, elat);
    request(v, lat);
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    if (lat > 0) begin
      chk({nm, "_found"}, 32'(found), 32'(ef));
      chk({nm, "_shift_operand"}, 32'(shift_operand), 32'(eso));
    end
    finish_req(nm);
  endtask

  vec_t vecs[6];

  initial begin
    int          lat;
    int          acc[2];
    int          xfer[2];
    logic        rf[2];
    logic [11:0] rso[2];
    int          n;
    int          m;
    int          cyc;
    logic        acc_now;
    logic        ef;
    logic [11:0] eso;
    int          elat;
    logic [11:0] held_so;
    logic [31:0] rv;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    value     = '0;

    vecs[0] = '{32'h000000FF, 1'b1, 12'h0FF};
    vecs[1] = '{32'hFF000000, 1'b1, 12'h4FF};
    vecs[2] = '{32'hF000000F, 1'b1, 12'h2FF};
    vecs[3] = '{32'h000003FC, 1'b1, 12'hFFF};
    vecs[4] = '{32'h00000101, 1'b0, 12'h000};
    vecs[5] = '{32'h00000000, 1'b1, 12'h000};

    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_found", 32'(found), 32'd0);
    chk("reset_shift_operand", 32'(shift_operand), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors: fixed expectations, latency from the model.
    for (int i = 0; i < 6; i++) begin
      model(vecs[i].value, ef, eso, elat);
      request(vecs[i].value, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(elat));
      chk($sformatf("vec%0d_found", i), 32'(found), 32'(vecs[i].exp_found));
      chk($sformatf("vec%0d_shift_operand", i), 32'(shift_operand), 32'(vecs[i].exp_so));
      finish_req($sformatf("vec%0d", i));
    end

    // Hold result with out_ready low; stray in_valid must be ignored.
    request(32'h00000000, lat);
    held_so = shift_operand;
    chk("hold_start_found", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      value    = 32'h000000FF;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_found", i), 32'(found), 32'd1);
      chk($sformatf("hold%0d_shift_operand", i), 32'(shift_operand), 32'(held_so));
      chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    finish_req("hold");

    // Reset mid-search while r = 3 is being evaluated.
    @(negedge clk);
    in_valid = 1'b1;
    value    = 32'h00000101;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midsearch_in_ready_before", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_found", 32'(found), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_req(32'h000000FF, "post_reset");

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    n   = 0;
    m   = 0;
    cyc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    value    = 32'hFF000000;
    for (int k = 0; k < 100 && m < 2; k++) begin
      if (k > 0) @(negedge clk);
      cyc++;
      acc_now = in_valid && in_ready;
      if (acc_now && n < 2) begin
        acc[n] = cyc;
        n++;
      end
      if (out_valid && out_ready && m < 2) begin
        xfer[m] = cyc;
        rf[m]   = found;
        rso[m]  = shift_operand;
        m++;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (n == 1) value = 32'h000003FC;
        else        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_transfers", 32'(m), 32'd2);
    if (m == 2 && n == 2) begin
      chk("b2b_second_accept", 32'(acc[1]), 32'(xfer[0] + 1));
      chk("b2b_r0_found", 32'(rf[0]), 32'd1);
      chk("b2b_r0_shift_operand", 32'(rso[0]), 32'h4FF);
      chk("b2b_r1_found", 32'(rf[1]), 32'd1);
      chk("b2b_r1_shift_operand", 32'(rso[1]), 32'hFFF);
    end
    @(posedge clk);
    #1;

    // Random: mix of constructed-encodable and arbitrary values.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1)
        rv = ror32($urandom_range(255, 0), 2 * $urandom_range(15, 0));
      else
        rv = $urandom;
      check_req(rv, $sformatf("rand%0d_%08h", i, rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
